// File: rtl/sel_rr_nway_if.sv
// Request/grant bundle for one node of a select tree.
// The selecting block sits on the slave modport; whoever drives requests uses master.
interface sel_rr_nway_if #(
  parameter int NREQ = 16,
  parameter int IW   = $clog2(NREQ)
);
  logic [NREQ-1:0] req_i;
  logic            grant_i;
  logic            ack_i;
  logic            flush_i;
  logic            req_o;
  logic            gnt_vld_o;
  logic [NREQ-1:0] gnt_vec_o;
  logic [IW-1:0]   gnt_idx_o;

  modport master (
    output req_i, grant_i, ack_i, flush_i,
    input  req_o, gnt_vld_o, gnt_vec_o, gnt_idx_o
  );

  modport slave (
    input  req_i, grant_i, ack_i, flush_i,
    output req_o, gnt_vld_o, gnt_vec_o, gnt_idx_o
  );
endinterface

// File: rtl/sel_rr_nway.sv
// N-way select node: holds one grant until acked, then reselects back-to-back.
// Define SEL_RR_PRIO_EN for a rotating priority pointer; otherwise lowest index wins.
module sel_rr_nway #(
  parameter int NREQ = 16,
  parameter int IW   = $clog2(NREQ)
) (
  input logic         clk,
  input logic         rst,
  sel_rr_nway_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic [IW-1:0]   idx_inc;
  logic [IW-1:0]   ack_base;
  logic [IW-1:0]   base;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] held_vec;

`ifdef SEL_RR_PRIO_EN
  localparam bit ROTATE = 1'b1;
  logic [IW-1:0] ptr_q, ptr_nxt;
`else
  localparam bit ROTATE = 1'b0;
  logic [IW-1:0] ptr_q;
  assign ptr_q = '0;
`endif

  // First set bit at or above base; if none, first set bit overall (the wrap).
  function automatic logic [IW-1:0] pick_idx(input logic [NREQ-1:0] vec,
                                             input logic [IW-1:0]   start);
    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          hi_any;
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= start) begin
          hi_idx = IW'(i);
          hi_any = 1'b1;
        end
      end
    end
    return hi_any ? hi_idx : lo_idx;
  endfunction

  assign held_vec = NREQ'(1) << idx_q;
  assign idx_inc  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
  assign ack_base = ROTATE ? idx_inc : ptr_q;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cand      = '0;
    base      = ptr_q;
`ifdef SEL_RR_PRIO_EN
    ptr_nxt   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        cand = bus.req_i;
        if (bus.grant_i && |cand) begin
          state_nxt = HOLD;
          idx_nxt   = pick_idx(cand, base);
        end
      end
      HOLD: begin
        if (bus.ack_i) begin
          // The acked entry is masked so it cannot win twice in a row.
          cand = bus.req_i & ~held_vec;
          base = ack_base;
`ifdef SEL_RR_PRIO_EN
          ptr_nxt = idx_inc;
`endif
          if (bus.grant_i && |cand) begin
            idx_nxt = pick_idx(cand, base);
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end
      end
    endcase

    // Flush discards the grant and any pending pointer advance.
    if (bus.flush_i) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
`ifdef SEL_RR_PRIO_EN
      ptr_nxt   = ptr_q;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

`ifdef SEL_RR_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end
`endif

  assign bus.req_o     = |bus.req_i;
  assign bus.gnt_vld_o = (state_q == HOLD);
  assign bus.gnt_vec_o = (state_q == HOLD) ? held_vec : '0;
  assign bus.gnt_idx_o = idx_q;

endmodule

// File: tb/tb_sel_rr_nway.sv
// Scoreboard bench for sel_rr_nway (NREQ=8): directed vectors push expectations,
// a negedge monitor pops and compares, and also checks output invariants every cycle.
module tb_sel_rr_nway;

`ifdef SEL_RR_PRIO_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] e_vec;

  sel_rr_nway_if #(.NREQ(8)) bus ();

  sel_rr_nway #(.NREQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; expectation describes outputs after that edge.
  task automatic step(input logic [7:0] req, input logic grant, input logic ack,
                      input logic flush, input logic r,
                      input logic ev, input logic [2:0] ei, input string nm);
    bus.req_i   = req;
    bus.grant_i = grant;
    bus.ack_i   = ack;
    bus.flush_i = flush;
    rst         = r;
    @(posedge clk);
    #1;
    exp_q.push_back('{vld: ev, idx: ei, nm: nm});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        e_vec = e.vld ? (8'd1 << e.idx) : 8'd0;
        check({e.nm, "_vld"}, 32'(bus.gnt_vld_o), 32'(e.vld));
        check({e.nm, "_idx"}, 32'(bus.gnt_idx_o), 32'(e.idx));
        check({e.nm, "_vec"}, 32'(bus.gnt_vec_o), 32'(e_vec));
      end
      check("inv_onehot0", 32'($onehot0(bus.gnt_vec_o)), 32'd1);
      check("inv_vec_idx", 32'(bus.gnt_vec_o),
            bus.gnt_vld_o ? 32'(8'd1 << bus.gnt_idx_o) : 32'd0);
      if (!bus.gnt_vld_o) check("inv_idx_zero", 32'(bus.gnt_idx_o), 32'd0);
      check("inv_req_o", 32'(bus.req_o), 32'(|bus.req_i));
    end
  end

  initial begin
    bus.req_i   = '0;
    bus.grant_i = 1'b0;
    bus.ack_i   = 1'b0;
    bus.flush_i = 1'b0;

    // Reset state
    step(8'h00, 0, 0, 0, 1, 0, 0, "reset");
    mon_en = 1'b1;
    step(8'h00, 0, 0, 0, 1, 0, 0, "reset2");

    // First selection and hold stability
    step(8'b0010_0100, 1, 0, 0, 0, 1, 2, "sel_first");
    for (int k = 0; k < 3; k++) step(8'h00, 0, 0, 0, 0, 1, 2, "hold_stable");
    step(8'h00, 1, 1, 0, 0, 0, 0, "ack_to_idle");
    step(8'h00, 1, 1, 0, 0, 0, 0, "idle_ack_ignored");
    step(8'hFF, 0, 0, 0, 0, 0, 0, "idle_no_grant");
    step(8'hFF, 1, 0, 1, 0, 0, 0, "flush_blocks_sel");

    // Back-to-back stream with every cycle acked
    step(8'h00, 0, 0, 0, 1, 0, 0, "reset3");
    step(8'hFF, 1, 0, 0, 0, 1, 0, "stream_0");
    for (int k = 1; k <= 8; k++)
      step(8'hFF, 1, 1, 0, 0, 1, ROT ? 3'(k % 8) : 3'(k % 2), "stream");
    step(8'hFF, 0, 1, 0, 0, 0, 0, "ack_no_grant");

    // Pointer at 6, then wrap-around
    step(8'h00, 0, 0, 0, 1, 0, 0, "reset4");
    step(8'b0010_0000, 1, 0, 0, 0, 1, 5, "sel_5");
    step(8'h00, 0, 1, 0, 0, 0, 0, "ack_5");
    step(8'b1000_0010, 1, 0, 0, 0, 1, ROT ? 3'd7 : 3'd1, "ptr6_sel");
    step(8'b1000_0010, 1, 1, 0, 0, 1, ROT ? 3'd1 : 3'd7, "wrap_sel");
    step(8'h00, 0, 1, 0, 0, 0, 0, "wrap_ack");

    // Flush with ack leaves pointer alone
    step(8'b0000_1000, 1, 0, 0, 0, 1, 3, "sel_3");
    step(8'hFF, 1, 1, 1, 0, 0, 0, "flush_ack");
    step(8'b0000_1010, 1, 0, 0, 0, 1, ROT ? 3'd3 : 3'd1, "ptr_after_flush");

    // Reset mid-hold beats ack and grant; pointer back to 0
    step(8'hFF, 1, 1, 0, 1, 0, 0, "rst_mid_hold");
    step(8'b0000_0101, 1, 0, 0, 0, 1, 0, "sel_after_rst");
    step(8'h00, 0, 1, 0, 0, 0, 0, "final_ack");

    // Random traffic: invariants only
    for (int c = 0; c < 2000; c++) begin
      bus.req_i   = 8'($urandom);
      bus.grant_i = ($urandom_range(0, 3) != 0);
      bus.ack_i   = 1'($urandom_range(0, 1));
      bus.flush_i = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
